// File: rtl/unit_mant_add_norm_if.sv
// Operand/result handshake bundle for the FP32 mantissa add/normalize/round unit.
// The master drives operands and consumes results; the slave is the unit itself.
interface unit_mant_add_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] Augend;
    logic [27:0] Addend;
    logic        Eff_sub;
    logic [7:0]  E_big;
    logic        S_big;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Ovf;
    logic        Unf;
    logic        Zero;

    modport master (
        output in_valid, Augend, Addend, Eff_sub, E_big, S_big, out_ready,
        input  in_ready, out_valid, Result, Ovf, Unf, Zero
    );

    modport slave (
        input  in_valid, Augend, Addend, Eff_sub, E_big, S_big, out_ready,
        output in_ready, out_valid, Result, Ovf, Unf, Zero
    );
endinterface

// File: rtl/unit_mant_add_norm.sv
// FP32 mantissa adder / normalizer / rounder.
// Adds or subtracts two aligned 28-bit mantissas ({hidden, 23 frac, 4 GRS}),
// normalizes left one bit per cycle, rounds to nearest-even and packs the
// single-precision result. One operation in flight at a time.
module unit_mant_add_norm (
    input  logic clk,
    input  logic rst_n,
    unit_mant_add_norm_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADD   = 3'd1;
    localparam logic [2:0] NORM  = 3'd2;
    localparam logic [2:0] ROUND = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Registered state
    logic [2:0]  state;
    logic [27:0] aug_q;
    logic [27:0] add_q;
    logic        eff_sub_q;
    logic [7:0]  e_big_q;
    logic        s_big_q;
    logic [28:0] sum_q;     // bit 28 is the add carry-out
    logic [8:0]  exp_q;     // one spare bit so overflow past 255 is visible
    logic [31:0] result_q;
    logic        ovf_q;
    logic        unf_q;
    logic        zero_q;

    // Next-state values
    logic [2:0]  nxt_state;
    logic [27:0] nxt_aug;
    logic [27:0] nxt_add;
    logic        nxt_eff_sub;
    logic [7:0]  nxt_e_big;
    logic        nxt_s_big;
    logic [28:0] nxt_sum;
    logic [8:0]  nxt_exp;
    logic [31:0] nxt_result;
    logic        nxt_ovf;
    logic        nxt_unf;
    logic        nxt_zero;

    // Rounding datapath
    logic        rnd_lsb;
    logic        rnd_g;
    logic        rnd_rs;
    logic        rnd_up;
    logic [23:0] rnd_frac;  // bit 23 is the rounding carry
    logic [8:0]  rnd_exp;
    logic        rnd_ovf;

    // Adder datapath
    logic [28:0] add_sum;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.Result    = result_q;
    assign bus.Ovf       = ovf_q;
    assign bus.Unf       = unf_q;
    assign bus.Zero      = zero_q;

    // Effective add/subtract; Augend >= Addend so the difference never wraps
    always_comb begin
        add_sum = eff_sub_q ? ({1'b0, aug_q} - {1'b0, add_q})
                            : ({1'b0, aug_q} + {1'b0, add_q});
    end

    // Round-to-nearest-even on the normalized sum, including carry into exponent
    always_comb begin
        rnd_lsb  = sum_q[4];
        rnd_g    = sum_q[3];
        rnd_rs   = |sum_q[2:0];
        rnd_up   = rnd_g & (rnd_rs | rnd_lsb);
        rnd_frac = {1'b0, sum_q[26:4]} + {23'd0, rnd_up};
        rnd_exp  = exp_q + {8'd0, rnd_frac[23]};
        // Covers both a carry-normalize that already reached 255 and a
        // rounding carry that pushes the exponent there
        rnd_ovf  = (rnd_exp >= 9'd255);
    end

    // Sequencer: next-state and datapath updates for each phase
    always_comb begin
        nxt_state   = state;
        nxt_aug     = aug_q;
        nxt_add     = add_q;
        nxt_eff_sub = eff_sub_q;
        nxt_e_big   = e_big_q;
        nxt_s_big   = s_big_q;
        nxt_sum     = sum_q;
        nxt_exp     = exp_q;
        nxt_result  = result_q;
        nxt_ovf     = ovf_q;
        nxt_unf     = unf_q;
        nxt_zero    = zero_q;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    nxt_aug     = bus.Augend;
                    nxt_add     = bus.Addend;
                    nxt_eff_sub = bus.Eff_sub;
                    nxt_e_big   = bus.E_big;
                    nxt_s_big   = bus.S_big;
                    nxt_state   = ADD;
                end
            end

            ADD: begin
                nxt_sum   = add_sum;
                nxt_exp   = {1'b0, e_big_q};
                nxt_state = NORM;
            end

            NORM: begin
                if (sum_q[28]) begin
                    // Carry-out: shift right once, folding the dropped bit into sticky
                    nxt_sum   = {1'b0, sum_q[28:2], sum_q[1] | sum_q[0]};
                    nxt_exp   = exp_q + 9'd1;
                    nxt_state = ROUND;
                end else if (sum_q == 29'd0) begin
                    // Exact cancellation is always +0
                    nxt_result = 32'd0;
                    nxt_zero   = 1'b1;
                    nxt_state  = DONE;
                end else if (sum_q[27]) begin
                    nxt_state = ROUND;
                end else if (exp_q == 9'd1) begin
                    // No denormal support: flush to signed zero
                    nxt_result = {s_big_q, 31'd0};
                    nxt_unf    = 1'b1;
                    nxt_state  = DONE;
                end else begin
                    nxt_sum = {sum_q[27:0], 1'b0};
                    nxt_exp = exp_q - 9'd1;
                end
            end

            ROUND: begin
                if (rnd_ovf) begin
                    nxt_result = {s_big_q, 8'hFF, 23'd0};
                    nxt_ovf    = 1'b1;
                end else begin
                    nxt_result = {s_big_q, rnd_exp[7:0], rnd_frac[22:0]};
                end
                nxt_state = DONE;
            end

            DONE: begin
                // Result stays put; flags drop as the consumer takes it
                if (bus.out_ready) begin
                    nxt_ovf   = 1'b0;
                    nxt_unf   = 1'b0;
                    nxt_zero  = 1'b0;
                    nxt_state = IDLE;
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            aug_q     <= 28'd0;
            add_q     <= 28'd0;
            eff_sub_q <= 1'b0;
            e_big_q   <= 8'd0;
            s_big_q   <= 1'b0;
            sum_q     <= 29'd0;
            exp_q     <= 9'd0;
            result_q  <= 32'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state     <= nxt_state;
            aug_q     <= nxt_aug;
            add_q     <= nxt_add;
            eff_sub_q <= nxt_eff_sub;
            e_big_q   <= nxt_e_big;
            s_big_q   <= nxt_s_big;
            sum_q     <= nxt_sum;
            exp_q     <= nxt_exp;
            result_q  <= nxt_result;
            ovf_q     <= nxt_ovf;
            unf_q     <= nxt_unf;
            zero_q    <= nxt_zero;
        end
    end

endmodule
